idct_1d: RTL
============

IDCT_1D -- requirements
Module: idct_1d

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst, with the reset polarity and synchronicity fixed as stated.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-004 enb  input  1  sample-enable; data_in is consumed on a rising clk edge only when enb=1.
REQ-005 data_in  input  10  signed two's-complement DCT coefficient X[k]; each block is 8 coefficients, k=0..7 in order.
REQ-006 data_out  output  8  unsigned reconstructed pixel x[n]; n=0..7 in order.
REQ-007 out_enb  output  1  1 while data_out holds a valid pixel.

Function
REQ-008 Coefficient table, fixed constants: C[n][k] = round(128 * a(k) * cos((2n+1)*k*pi/16)), 9-bit signed; a(0)=1/sqrt(2), a(k>0)=1 (e.g. C[n][0]=91, C[0][1]=126).
REQ-009 Input counter kin (3 bit, 0..7) SHALL advance only on edges with enb=1; it wraps 7->0; enb=0 holds kin and all accumulators.
REQ-010 Per accepted coefficient: acc[n] += data_in * C[n][kin] for all n in parallel; acc[n] is 21-bit signed; no overflow is possible.
REQ-011 On the edge that accepts kin=7, the final sums (acc[n] + data_in*C[n][7]) SHALL be converted and loaded into an 8-entry output buffer; all acc[n] clear to 0 on that same edge.
REQ-012 Conversion: p = ((sum + 128) >>> 8) + 128 (arithmetic shift); data_out = 0 if p<0, 255 if p>255, else p[7:0].
REQ-013 Output sequencer: from the edge after the load, data_out presents x[0]..x[7] on 8 consecutive cycles with out_enb=1, independent of enb.
REQ-014 Latency: kin=7 accepted at edge E -> x[0] valid after edge E+1, x[7] after edge E+8.
REQ-015 After x[7], out_enb SHALL drop to 0 and data_out holds its last value, unless a new load occurred at the same edge as x[7] was presented.
REQ-016 Back-to-back blocks (enb held 1): the next load occurs at edge E+8, so x[0] of block 2 follows x[7] of block 1 with no gap and out_enb stays 1.
REQ-017 A load while the output buffer is still draining is impossible under REQ-009, because each load requires 8 accepted inputs; no overrun handling is required.
REQ-018 enb gaps mid-block SHALL only delay the load; results are identical to the gapless case.

Reset
REQ-019 rst=0 SHALL asynchronously force: kin=0, all acc[n]=0, output sequencer idle, data_out=8'd0, out_enb=0.
REQ-020 A partial input block or an undrained output block at reset is discarded; the first block after reset release starts at k=0.
REQ-021 Reset release is synchronous to clk in use: the first coefficient is sampled on the first rising edge with rst=1 and enb=1.

Verification
REQ-022 All-zero block -> eight outputs of 128, out_enb=1 for exactly 8 cycles starting 1 cycle after the kin=7 edge.
REQ-023 X[0]=256, X[1..7]=0 -> every sum = 23296; output 219 for all 8 pixels.
REQ-024 Clamp: X[0]=511 -> 255 for all pixels; X[0]=-512 -> 0 for all pixels.
REQ-025 Two consecutive blocks with enb held 1 -> 16 contiguous valid outputs with no out_enb gap; then enb=1 with a 3-cycle enb=0 gap after k=4 in the next block -> outputs identical, delayed 3 cycles.
REQ-026 rst asserted after k=5 of a block -> data_out=0 and out_enb=0 immediately; re-sending a full block after release -> correct values, no contamination from the partial block.
REQ-027 Random coefficients (10k blocks) -> bit-exact match against a model of REQ-008..REQ-012.

Source files
------------

// File: rtl/idct_1d_if.sv
// idct_1d_if: coefficient-in / pixel-out bus for the 8-point 1-D IDCT.
//   enb      - sample-enable; data_in is consumed on a rising clk edge when 1
//   data_in  - signed 10-bit DCT coefficient X[k], k = 0..7 in order
//   data_out - unsigned 8-bit reconstructed pixel x[n], n = 0..7 in order
//   out_enb  - 1 while data_out holds a valid pixel
interface idct_1d_if;
  logic       enb;
  logic [9:0] data_in;
  logic [7:0] data_out;
  logic       out_enb;

  // Coefficient source side
  modport master (
    output enb,
    output data_in,
    input  data_out,
    input  out_enb
  );

  // IDCT engine side
  modport slave (
    input  enb,
    input  data_in,
    output data_out,
    output out_enb
  );
endinterface

// File: rtl/idct_1d.sv
// idct_1d: 8-point 1-D inverse DCT with 7-bit fixed-point basis.
// Coefficients arrive serially (k = 0..7); all eight outputs accumulate in
// parallel. On the edge that accepts k = 7 the sums are rounded, biased by
// 128, clamped to 0..255 and loaded into an output buffer that is then
// presented one pixel per cycle.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-low reset
//   bus - idct_1d_if.slave (enb, data_in in; data_out, out_enb out)
module idct_1d (
  input  logic      clk,
  input  logic      rst,
  idct_1d_if.slave  bus
);

  localparam int unsigned N      = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned DIN_W  = 10;
  localparam int unsigned COEF_W = 9;
  localparam int unsigned PROD_W = 19;
  localparam int unsigned ACC_W  = 21;
  localparam int unsigned RND_W  = 22;
  localparam int unsigned SHR_W  = 14;
  localparam int unsigned PIX_W  = 8;

  typedef enum logic {
    S_IDLE,
    S_DRAIN
  } state_t;

  // Basis coefficient C[n][k] = round(128 * a(k) * cos((2n+1)k*pi/16)).
  // The angle index (2n+1)k is folded mod 32 onto a quarter-wave table.
  function automatic logic signed [COEF_W-1:0] coef(
    input logic [IDX_W-1:0] n,
    input logic [IDX_W-1:0] k
  );
    logic [6:0]               ang;
    logic [4:0]               m;
    logic [3:0]               r;
    logic signed [COEF_W-1:0] mag;
    ang = 7'({n, 1'b1}) * 7'(k);
    m   = 5'(ang);
    if (m > 5'd16) m = 5'(6'd32 - {1'b0, m});
    if (m > 5'd8) r = 4'(5'd16 - m);
    else          r = 4'(m);
    case (r)
      4'd1:    mag = 9'sd126;
      4'd2:    mag = 9'sd118;
      4'd3:    mag = 9'sd106;
      4'd4:    mag = 9'sd91;
      4'd5:    mag = 9'sd71;
      4'd6:    mag = 9'sd49;
      4'd7:    mag = 9'sd25;
      default: mag = 9'sd0;
    endcase
    if (k == 3'd0)     coef = 9'sd91;
    else if (m > 5'd8) coef = -mag;
    else               coef = mag;
  endfunction

  // Round to nearest (>> 8), re-bias to mid-grey, saturate to a byte.
  function automatic logic [PIX_W-1:0] to_pixel(input logic signed [ACC_W-1:0] s);
    logic signed [RND_W-1:0] rnd;
    logic signed [SHR_W-1:0] shr;
    logic signed [SHR_W:0]   p;
    rnd = RND_W'(s) + 22'sd128;
    shr = SHR_W'(rnd >>> 8);
    p   = (SHR_W + 1)'(shr) + 15'sd128;
    if (p < 15'sd0)        to_pixel = 8'd0;
    else if (p > 15'sd255) to_pixel = 8'd255;
    else                   to_pixel = p[PIX_W-1:0];
  endfunction

  logic [IDX_W-1:0]        kin;
  logic signed [ACC_W-1:0] acc     [N];
  logic signed [ACC_W-1:0] sum     [N];
  logic [PIX_W-1:0]        pix     [N];
  logic [PIX_W-1:0]        pix_buf [N];
  logic signed [DIN_W-1:0] din;
  logic                    load;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rd_idx, rd_idx_nxt;
  logic [PIX_W-1:0] data_out_q, data_out_nxt;
  logic             out_enb_q, out_enb_nxt;

  assign din  = $signed(bus.data_in);
  assign load = bus.enb && (kin == IDX_W'(N - 1));

  // Per-output MAC term for the current coefficient and the converted result
  always_comb begin
    for (int n = 0; n < N; n++) begin
      logic signed [PROD_W-1:0] prod;
      prod   = PROD_W'(din) * PROD_W'(coef(IDX_W'(n), kin));
      sum[n] = acc[n] + ACC_W'(prod);
      pix[n] = to_pixel(sum[n]);
    end
  end

  // Input counter, accumulators and output buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kin <= '0;
      for (int n = 0; n < N; n++) begin
        acc[n]     <= '0;
        pix_buf[n] <= '0;
      end
    end else if (bus.enb) begin
      kin <= IDX_W'(kin + 3'd1);
      for (int n = 0; n < N; n++) begin
        if (load) begin
          acc[n]     <= '0;
          pix_buf[n] <= pix[n];
        end else begin
          acc[n] <= sum[n];
        end
      end
    end
  end

  // Output sequencer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      rd_idx     <= '0;
      data_out_q <= '0;
      out_enb_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      rd_idx     <= rd_idx_nxt;
      data_out_q <= data_out_nxt;
      out_enb_q  <= out_enb_nxt;
    end
  end

  // Output sequencer next-state: a load arms the drain; a load landing on the
  // x[7] edge restarts it so consecutive blocks stream without a gap.
  always_comb begin
    state_nxt    = state;
    rd_idx_nxt   = rd_idx;
    data_out_nxt = data_out_q;
    out_enb_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (load) begin
          state_nxt  = S_DRAIN;
          rd_idx_nxt = '0;
        end
      end
      S_DRAIN: begin
        out_enb_nxt  = 1'b1;
        data_out_nxt = pix_buf[rd_idx];
        rd_idx_nxt   = IDX_W'(rd_idx + 3'd1);
        if (load) begin
          rd_idx_nxt = '0;
        end else if (rd_idx == IDX_W'(N - 1)) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt  = S_IDLE;
        rd_idx_nxt = '0;
      end
    endcase
  end

  assign bus.data_out = data_out_q;
  assign bus.out_enb  = out_enb_q;

endmodule
